// File: rtl/perf_pkg.sv
// Shared constants and types for the cache performance-counter readout path.
package perf_pkg;

  localparam int unsigned NUM_COUNTERS = 4;
  localparam logic [7:0]  FRAME_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } reader_state_t;

  // Enumeration order is the order counters appear on the wire.
  typedef enum logic [1:0] {
    HIT,
    MISS,
    READ,
    WRITE
  } ctr_sel_t;

  function automatic int unsigned frame_bytes(input int unsigned width);
    return 1 + NUM_COUNTERS * (width / 8);
  endfunction

endpackage

// File: rtl/snapshot_serializer.sv
// Snapshot register file for the four counters plus the counter/byte pointers
// that walk it little-endian, one byte per advance.
module snapshot_serializer
  import perf_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTHS = 32
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         load_i,
  input  logic                                         advance_i,
  input  logic [NUM_COUNTERS-1:0][COUNTER_WIDTHS-1:0]  values_i,
  output logic [7:0]                                   byte_o,
  output logic                                         is_last_o
);

  localparam int unsigned B  = COUNTER_WIDTHS / 8;
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(B - 1);

  logic [NUM_COUNTERS-1:0][COUNTER_WIDTHS-1:0] snap_q;
  ctr_sel_t                                    ctr_idx_q;
  logic [BW-1:0]                               byte_idx_q;
  logic [COUNTER_WIDTHS-1:0]                   cur_ctr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_q     <= '0;
      ctr_idx_q  <= HIT;
      byte_idx_q <= '0;
    end else if (load_i) begin
      snap_q     <= values_i;
      ctr_idx_q  <= HIT;
      byte_idx_q <= '0;
    end else if (advance_i) begin
      if (byte_idx_q == BYTE_LAST) begin
        byte_idx_q <= '0;
        ctr_idx_q  <= ctr_sel_t'(2'(ctr_idx_q) + 2'd1);
      end else begin
        byte_idx_q <= byte_idx_q + BW'(1);
      end
    end
  end

  assign cur_ctr   = snap_q[2'(ctr_idx_q)];
  assign byte_o    = 8'(cur_ctr >> {byte_idx_q, 3'b000});
  assign is_last_o = (ctr_idx_q == WRITE) && (byte_idx_q == BYTE_LAST);

endmodule

// File: rtl/perf_counter_reader.sv
// Counter readout engine: snapshots the four cache counters on request, optionally
// strobes a clear, and streams A5 + little-endian counter bytes over valid/ready.
module perf_counter_reader
  import perf_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTHS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COUNTER_WIDTHS-1:0] hit_value,
  input  logic [COUNTER_WIDTHS-1:0] miss_value,
  input  logic [COUNTER_WIDTHS-1:0] read_value,
  input  logic [COUNTER_WIDTHS-1:0] write_value,
  input  logic                      req_valid,
  input  logic                      req_clear,
  output logic                      req_ready,
  output logic                      clear_counters,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      out_last
);

  reader_state_t state_q;
  logic          clear_q;
  logic          load;
  logic          advance;
  logic [7:0]    ser_byte;
  logic          ser_last;
  logic [NUM_COUNTERS-1:0][COUNTER_WIDTHS-1:0] live_values;

  // Index 0 is the first counter streamed (hit), matching ctr_sel_t.
  assign live_values = {write_value, read_value, miss_value, hit_value};
  assign load        = (state_q == IDLE) && req_valid;
  assign advance     = (state_q == PAYLOAD) && out_ready;

  snapshot_serializer #(
    .COUNTER_WIDTHS(COUNTER_WIDTHS)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .advance_i(advance),
    .values_i (live_values),
    .byte_o   (ser_byte),
    .is_last_o(ser_last)
  );

  // Readout FSM; the clear strobe is a one-cycle pulse following acceptance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= HEADER;
            clear_q <= req_clear;
          end
        end
        HEADER: begin
          if (out_ready) state_q <= PAYLOAD;
        end
        PAYLOAD: begin
          if (out_ready && ser_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign clear_counters = clear_q;
  assign out_valid      = (state_q != IDLE);
  assign out_last       = (state_q == PAYLOAD) && ser_last;
  assign out_data       = (state_q == HEADER)  ? FRAME_HEADER :
                          (state_q == PAYLOAD) ? ser_byte     : 8'h00;

endmodule

// File: tb/tb_perf_counter_reader.sv
// Bench for perf_counter_reader: scoreboarded byte stream for 32-bit and 16-bit builds.
module tb_perf_counter_reader;
  import perf_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] hit_value, miss_value, read_value, write_value;
  logic        req_valid, req_clear, req_ready, clear_counters;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;

  logic [15:0] h16, m16, r16, w16;
  logic        rv16, rc16, rr16, cc16, ov16, or16, ol16;
  logic [7:0]  od16;

  int pass_cnt = 0;
  int total_cnt = 0;
  int byte_cnt = 0;
  int last_cnt = 0;
  int clr_cnt = 0;
  int stall_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] q16[$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;

  perf_counter_reader #(.COUNTER_WIDTHS(32)) dut (
    .clk(clk), .reset(reset),
    .hit_value(hit_value), .miss_value(miss_value),
    .read_value(read_value), .write_value(write_value),
    .req_valid(req_valid), .req_clear(req_clear), .req_ready(req_ready),
    .clear_counters(clear_counters),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  perf_counter_reader #(.COUNTER_WIDTHS(16)) dut16 (
    .clk(clk), .reset(reset),
    .hit_value(h16), .miss_value(m16),
    .read_value(r16), .write_value(w16),
    .req_valid(rv16), .req_clear(rc16), .req_ready(rr16),
    .clear_counters(cc16),
    .out_valid(ov16), .out_ready(or16),
    .out_data(od16), .out_last(ol16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on each pending handshake and checks stall stability.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      if (clear_counters) clr_cnt++;
      if (stall_q) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== stall_data || out_last !== stall_last)
          $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   out_valid, out_data, out_last, stall_data, stall_last);
        else pass_cnt++;
      end
      if (out_valid && out_ready) begin
        byte_cnt++;
        if (out_last) last_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_byte: got last=%b data=%h, want nothing", out_last, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e)
            $display("FAIL stream_byte: got last=%b data=%h, want last=%b data=%h",
                     out_last, out_data, e[8], e[7:0]);
          else pass_cnt++;
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (stall_q) stall_cnt++;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] h, input logic [31:0] m,
                            input logic [31:0] r, input logic [31:0] w);
    logic [31:0] v [4];
    v[0] = h; v[1] = m; v[2] = r; v[3] = w;
    exp_q.push_back({1'b0, 8'hA5});
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back({(c == 3 && b == 3), v[c][8*b +: 8]});
  endtask

  task automatic request(input logic clr);
    req_valid = 1'b1;
    req_clear = clr;
    tick();
    req_valid = 1'b0;
    req_clear = 1'b0;
  endtask

  task automatic wait_last(input int target, input int budget, output bit ok);
    int n = 0;
    while (last_cnt < target && n < budget) begin
      tick();
      n++;
    end
    ok = (last_cnt >= target);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 || clear_counters !== 1'b0)
      $display("FAIL reset_outputs: got v=%b l=%b d=%h clr=%b, want all 0",
               out_valid, out_last, out_data, clear_counters);
    else pass_cnt++;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    total_cnt++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: got ready=%b valid=%b, want ready=1 valid=0", req_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int c0 = clr_cnt;
    int b0 = byte_cnt;
    int l0 = last_cnt;
    bit ok;
    hit_value = 32'h11223344; miss_value = 32'd5;
    read_value = 32'hFFFFFFFF; write_value = 32'h0;
    out_ready = 1'b1;
    push_frame(hit_value, miss_value, read_value, write_value);
    request(1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0)
      $display("FAIL basic_header_latency: got v=%b d=%h l=%b, want v=1 d=a5 l=0",
               out_valid, out_data, out_last);
    else pass_cnt++;
    wait_last(l0 + 1, 40, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_timeout: got no out_last in 40 cycles, want one");
    else pass_cnt++;
    total_cnt++;
    if (byte_cnt - b0 !== 17) $display("FAIL basic_length: got %0d bytes, want 17", byte_cnt - b0);
    else pass_cnt++;
    total_cnt++;
    if (clr_cnt !== c0) $display("FAIL basic_no_clear: got %0d clear pulses, want 0", clr_cnt - c0);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL basic_leftover: got %0d pending, want 0", exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL basic_idle_after: got ready=%b valid=%b, want 1/0", req_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int c0 = clr_cnt;
    int l0 = last_cnt;
    bit ok;
    hit_value = 32'hCAFE0001; miss_value = 32'h00000102;
    read_value = 32'h7F; write_value = 32'h80000000;
    out_ready = 1'b1;
    push_frame(hit_value, miss_value, read_value, write_value);
    request(1'b1);
    total_cnt++;
    if (clear_counters !== 1'b1) $display("FAIL clear_t1: got %b, want 1", clear_counters);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (clear_counters !== 1'b0) $display("FAIL clear_t2: got %b, want 0", clear_counters);
    else pass_cnt++;
    wait_last(l0 + 1, 40, ok);
    total_cnt++;
    if (!ok) $display("FAIL clear_timeout: got no out_last, want one");
    else pass_cnt++;
    // Counter bank has cleared and sees no traffic.
    hit_value = '0; miss_value = '0; read_value = '0; write_value = '0;
    tick();
    push_frame(32'h0, 32'h0, 32'h0, 32'h0);
    request(1'b0);
    wait_last(l0 + 2, 40, ok);
    total_cnt++;
    if (!ok || exp_q.size() !== 0)
      $display("FAIL clear_zero_frame: got done=%b pending=%0d, want done=1 pending=0", ok, exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (clr_cnt - c0 !== 1) $display("FAIL clear_count: got %0d pulses, want 1", clr_cnt - c0);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    int l0 = last_cnt;
    int s0 = stall_cnt;
    int n = 0;
    hit_value = $urandom; miss_value = $urandom; read_value = $urandom; write_value = $urandom;
    out_ready = 1'b1;
    push_frame(hit_value, miss_value, read_value, write_value);
    request(1'b0);
    while (last_cnt == l0 && n < 300) begin
      hit_value = $urandom; miss_value = $urandom; read_value = $urandom; write_value = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    total_cnt++;
    if (last_cnt == l0) $display("FAIL bp_timeout: got no out_last in 300 cycles, want one");
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL bp_leftover: got %0d pending, want 0", exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt == s0) $display("FAIL bp_no_stalls: got 0 stall cycles, want >0");
    else pass_cnt++;
    tick();
  endtask

  task automatic test_busy();
    int l0 = last_cnt;
    int acc[$];
    int bad = 0;
    bit ok;
    hit_value = 32'h01020304; miss_value = 32'hA0B0C0D0;
    read_value = 32'h55; write_value = 32'h00FF00FF;
    out_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc.push_back(i);
        push_frame(hit_value, miss_value, read_value, write_value);
      end
      if (req_ready === out_valid) bad++;
      tick();
    end
    req_valid = 1'b0;
    total_cnt++;
    if (last_cnt - l0 !== 2)
      $display("FAIL busy_frames: got %0d frames completed in window, want 2", last_cnt - l0);
    else pass_cnt++;
    total_cnt++;
    if (acc.size() !== 3 || acc[0] !== 0 || acc[1] !== 18 || acc[2] !== 36)
      $display("FAIL busy_accept_cycles: got %0d accepts first=%0d second=%0d, want 3 at 0/18/36",
               acc.size(), (acc.size() > 0) ? acc[0] : -1, (acc.size() > 1) ? acc[1] : -1);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL busy_ready_during_frame: got %0d bad cycles, want 0", bad);
    else pass_cnt++;
    wait_last(l0 + 3, 40, ok);
    total_cnt++;
    if (!ok || exp_q.size() !== 0)
      $display("FAIL busy_drain: got done=%b pending=%0d, want done=1 pending=0", ok, exp_q.size());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    int c0 = clr_cnt;
    int l0 = last_cnt;
    int b0 = byte_cnt;
    int n = 0;
    bit ok;
    hit_value = 32'hDEADBEEF; miss_value = 32'h1; read_value = 32'h2; write_value = 32'h3;
    out_ready = 1'b1;
    push_frame(hit_value, miss_value, read_value, write_value);
    request(1'b1);
    while (byte_cnt < b0 + 6 && n < 40) begin
      tick();
      n++;
    end
    total_cnt++;
    if (byte_cnt < b0 + 6) $display("FAIL rst_mid_timeout: got %0d bytes, want 6", byte_cnt - b0);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    total_cnt++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || clear_counters !== 1'b0 || out_data !== 8'h00)
      $display("FAIL rst_mid_outputs: got v=%b l=%b clr=%b d=%h, want all 0",
               out_valid, out_last, clear_counters, out_data);
    else pass_cnt++;
    total_cnt++;
    if (last_cnt !== l0) $display("FAIL rst_mid_no_last: got %0d lasts, want 0", last_cnt - l0);
    else pass_cnt++;
    b0 = byte_cnt;
    push_frame(32'h0BADF00D, 32'h10, 32'h20, 32'h30);
    hit_value = 32'h0BADF00D; miss_value = 32'h10; read_value = 32'h20; write_value = 32'h30;
    request(1'b0);
    wait_last(l0 + 1, 40, ok);
    total_cnt++;
    if (!ok || byte_cnt - b0 !== 17 || exp_q.size() !== 0)
      $display("FAIL rst_mid_next_frame: got done=%b bytes=%0d pending=%0d, want 1/17/0",
               ok, byte_cnt - b0, exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (clr_cnt - c0 !== 1) $display("FAIL rst_mid_clear: got %0d pulses, want 1", clr_cnt - c0);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_width16();
    int n = 0;
    int got = 0;
    logic [8:0] e;
    h16 = 16'hBEEF; m16 = 16'h0102; r16 = 16'h00FF; w16 = 16'h8000;
    or16 = 1'b1;
    q16.push_back({1'b0, 8'hA5});
    q16.push_back({1'b0, 8'hEF}); q16.push_back({1'b0, 8'hBE});
    q16.push_back({1'b0, 8'h02}); q16.push_back({1'b0, 8'h01});
    q16.push_back({1'b0, 8'hFF}); q16.push_back({1'b0, 8'h00});
    q16.push_back({1'b0, 8'h00}); q16.push_back({1'b1, 8'h80});
    rv16 = 1'b1;
    tick();
    rv16 = 1'b0;
    while (q16.size() > 0 && n < 40) begin
      @(negedge clk);
      if (ov16 && or16) begin
        e = q16.pop_front();
        got++;
        total_cnt++;
        if ({ol16, od16} !== e)
          $display("FAIL w16_byte%0d: got last=%b data=%h, want last=%b data=%h",
                   got, ol16, od16, e[8], e[7:0]);
        else pass_cnt++;
      end
      n++;
    end
    tick();
    total_cnt++;
    if (got !== frame_bytes(16) || rr16 !== 1'b1 || ov16 !== 1'b0)
      $display("FAIL w16_frame: got %0d bytes ready=%b valid=%b, want 9/1/0", got, rr16, ov16);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    hit_value = '0; miss_value = '0; read_value = '0; write_value = '0;
    req_valid = 1'b0; req_clear = 1'b0; out_ready = 1'b1;
    h16 = '0; m16 = '0; r16 = '0; w16 = '0;
    rv16 = 1'b0; rc16 = 1'b0; or16 = 1'b1;
    test_reset();
    test_basic();
    test_clear();
    test_backpressure();
    test_busy();
    test_reset_mid();
    test_width16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
